// File: rtl/mlaccel_spi_slave.sv
// Oversampled SPI / dual / quad host-link slave with a small outbound byte FIFO.
// The serial clock is only sampled through synchronisers; all state runs on `clock`.
module mlaccel_spi_slave #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned OUT_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_csb_di,
  input  logic       spi_clk_di,
  input  logic [3:0] spi_io_di,
  output logic [3:0] spi_io_do,
  output logic [3:0] spi_io_oe,
  output logic       spi_rdy_do,
  output logic       spi_err_do,
  output logic       din_valid,
  output logic       din_start,
  output logic [7:0] din_data,
  input  logic       dout_valid,
  output logic       dout_ready,
  input  logic [7:0] dout_data
);

  localparam int unsigned AW = $clog2(OUT_DEPTH);
  localparam int unsigned BEATS = 8 / LANES;
  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d, clk_sync_q, clk_sync_d;
  logic [3:0]             io_sync_q [SYNC_STAGES];
  logic [3:0]             io_sync_d [SYNC_STAGES];
  logic                   csb_hist_q, csb_hist_d, clk_hist_q, clk_hist_d;

  logic       blocked_q, blocked_d;
  logic [2:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic       err_q, err_d;
  logic       tx_active_q, tx_active_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       din_valid_q, din_valid_d;
  logic       din_start_q, din_start_d;
  logic [7:0] din_data_q, din_data_d;

  logic [7:0]  mem_q [OUT_DEPTH];
  logic [7:0]  mem_d [OUT_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        ready_q, ready_d;
  logic        rdy_q, rdy_d;

  logic        csb_s, clk_s;
  logic [3:0]  io_s;
  logic        csb_fall, csb_rise, clk_rise, clk_fall, in_txn;
  logic        push, pop, slot_load, fifo_empty;
  logic [7:0]  rx_next;
  logic [AW:0] count_d;
  logic        unused_io;

  assign csb_s     = csb_sync_q[SYNC_STAGES-1];
  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign io_s      = io_sync_q[SYNC_STAGES-1];
  assign unused_io = ^io_s;

  always_comb begin
    csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], spi_csb_di};
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], spi_clk_di};
    io_sync_d[0] = spi_io_di;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      io_sync_d[i] = io_sync_q[i-1];
    end
    csb_hist_d = csb_s;
    clk_hist_d = clk_s;
  end

  always_comb begin
    csb_fall   = csb_hist_q & ~csb_s & ~blocked_q;
    csb_rise   = ~csb_hist_q & csb_s;
    clk_rise   = ~clk_hist_q & clk_s;
    clk_fall   = clk_hist_q & ~clk_s;
    in_txn     = ~csb_s & ~blocked_q;
    fifo_empty = (wptr_q == rptr_q);
    rx_next    = 8'({rx_shift_q, io_s[LANES-1:0]});

    blocked_d   = blocked_q & ~csb_s;
    cnt_d       = cnt_q;
    first_d     = first_q;
    err_d       = err_q;
    tx_active_d = tx_active_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    din_valid_d = 1'b0;
    din_start_d = 1'b0;
    din_data_d  = din_data_q;
    slot_load   = 1'b0;
    pop         = 1'b0;

    if (csb_fall) begin
      cnt_d      = '0;
      first_d    = 1'b1;
      err_d      = 1'b0;
      rx_shift_d = '0;
      slot_load  = 1'b1;
    end else if (csb_rise) begin
      // Any byte already in the tx shifter is dropped, not returned to the FIFO.
      tx_active_d = 1'b0;
      tx_shift_d  = '0;
      rx_shift_d  = '0;
      cnt_d       = '0;
      if (!blocked_q && cnt_q != '0) begin
        err_d = 1'b1;
      end
    end else if (in_txn) begin
      if (clk_rise) begin
        rx_shift_d = rx_next;
        if (cnt_q == LAST_BEAT) begin
          cnt_d     = '0;
          first_d   = 1'b0;
          slot_load = 1'b1;
          // Multi-lane links are half duplex: a slot we drove carries no host data.
          if (LANES == 1 || !tx_active_q) begin
            din_valid_d = 1'b1;
            din_start_d = first_q;
            din_data_d  = rx_next;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end else if (clk_fall && tx_active_q && cnt_q != '0) begin
        tx_shift_d = tx_shift_q << LANES;
      end
    end

    if (slot_load) begin
      if (!fifo_empty) begin
        pop         = 1'b1;
        tx_shift_d  = mem_q[rptr_q[AW-1:0]];
        tx_active_d = 1'b1;
      end else begin
        tx_shift_d  = '0;
        tx_active_d = 1'b0;
      end
    end

    push  = dout_valid & ready_q;
    mem_d = mem_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = dout_data;
    end
    wptr_d  = wptr_q + (AW+1)'(push);
    rptr_d  = rptr_q + (AW+1)'(pop);
    count_d = wptr_d - rptr_d;
    ready_d = (count_d != (AW+1)'(OUT_DEPTH));
    rdy_d   = (count_d != '0);
  end

  always_ff @(posedge clock) begin
    csb_sync_q <= csb_sync_d;
    clk_sync_q <= clk_sync_d;
    io_sync_q  <= io_sync_d;
    csb_hist_q <= csb_hist_d;
    clk_hist_q <= clk_hist_d;
    mem_q      <= mem_d;
    if (reset) begin
      // Reset while the host holds csb low: ignore the rest of that transaction.
      blocked_q   <= ~csb_s;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      tx_active_q <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      din_valid_q <= 1'b0;
      din_start_q <= 1'b0;
      din_data_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ready_q     <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      blocked_q   <= blocked_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      err_q       <= err_d;
      tx_active_q <= tx_active_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      din_valid_q <= din_valid_d;
      din_start_q <= din_start_d;
      din_data_q  <= din_data_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ready_q     <= ready_d;
      rdy_q       <= rdy_d;
    end
  end

  always_comb begin
    spi_io_do = '0;
    spi_io_oe = '0;
    if (LANES == 1) begin
      spi_io_do[1] = tx_shift_q[7];
      spi_io_oe[1] = tx_active_q;
    end else begin
      spi_io_do[LANES-1:0] = tx_shift_q[7 -: LANES];
      spi_io_oe[LANES-1:0] = {LANES{tx_active_q}};
    end
  end

  assign spi_rdy_do = rdy_q;
  assign spi_err_do = err_q;
  assign din_valid  = din_valid_q;
  assign din_start  = din_start_q;
  assign din_data   = din_data_q;
  assign dout_ready = ready_q;

endmodule
